des_block_ctrl: RTL and testbench

Sequential block-level controller for the combinational `DES` core. It accepts 64-bit plaintext blocks over a valid/ready handshake and holds the key register. It applies optional CBC chaining, drives the `DES` instance, and registers the 64-bit ciphertext. The ciphertext is presented on a valid/ready output port. The block sits directly around `DES`: it feeds `DES.in` and `DES.key`, and consumes `DES.out`.

---
 rtl/des_block_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_des_block_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/des_block_ctrl.sv
// des_block_ctrl: valid/ready block controller wrapped around a combinational DES core.
// Build option: define DES_CBC_EN for CBC chaining (chain register, iv_load honoured); default build is ECB.
// Ports: clk, rst (async, active high); key_in/key_load and iv_in/iv_load load registers in IDLE only;
//        din/din_valid/din_ready plaintext in; dout/dout_valid/dout_ready ciphertext out; busy = state not IDLE.
// Parameter LATENCY (1..4): settle cycles given to the DES path before its result is captured.

// des: single-block combinational DES encryption.
// Ports: i_in plaintext, i_key 64-bit key with parity bits (ignored), o_out ciphertext.
module des (
    input  logic [63:0] i_in,
    input  logic [63:0] i_key,
    output logic [63:0] o_out
);
    // Tables use the standard 1-based numbering where bit 1 is the MSB.
    localparam int IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
         2, 8, 24, 14, 32, 27,  3,  9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    // Index = {box, row, column}; row comes from the outer bits of each 6-bit group.
    localparam int SBOX [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    logic [63:0] w_ip, w_pre;
    logic [55:0] w_cd0;
    logic [31:0] w_l [17];
    logic [31:0] w_r [17];
    logic [27:0] w_c [17];
    logic [27:0] w_d [17];
    logic        w_unused_par;

    // Parity bits of the key never reach the key schedule.
    assign w_unused_par = ^{i_key[56], i_key[48], i_key[40], i_key[32], i_key[24], i_key[16], i_key[8], i_key[0]};

    genvar g, j;
    for (j = 0; j < 64; j++) begin : g_ip
        assign w_ip[63-j]  = i_in[64-IP[j]];
        assign o_out[63-j] = w_pre[64-FP[j]];
    end
    for (j = 0; j < 56; j++) begin : g_pc1
        assign w_cd0[55-j] = i_key[64-PC1[j]];
    end

    assign w_l[0] = w_ip[63:32];
    assign w_r[0] = w_ip[31:0];
    assign w_c[0] = w_cd0[55:28];
    assign w_d[0] = w_cd0[27:0];

    for (g = 0; g < 16; g++) begin : g_rnd
        logic [47:0] w_k, w_x;
        logic [31:0] w_s, w_f;
        assign w_c[g+1] = SHIFTS[g] == 1 ? {w_c[g][26:0], w_c[g][27]} : {w_c[g][25:0], w_c[g][27:26]};
        assign w_d[g+1] = SHIFTS[g] == 1 ? {w_d[g][26:0], w_d[g][27]} : {w_d[g][25:0], w_d[g][27:26]};
        for (j = 0; j < 48; j++) begin : g_k
            if (PC2[j] <= 28) begin : g_kc
                assign w_k[47-j] = w_c[g+1][28-PC2[j]];
            end else begin : g_kd
                assign w_k[47-j] = w_d[g+1][56-PC2[j]];
            end
            assign w_x[47-j] = w_r[g][32-E[j]] ^ w_k[47-j];
        end
        for (j = 0; j < 8; j++) begin : g_s
            assign w_s[31-4*j -: 4] = 4'(SBOX[{3'(j), w_x[47-6*j], w_x[42-6*j], w_x[46-6*j -: 4]}]);
        end
        for (j = 0; j < 32; j++) begin : g_p
            assign w_f[31-j] = w_s[32-P[j]];
        end
        assign w_l[g+1] = w_r[g];
        assign w_r[g+1] = w_l[g] ^ w_f;
    end

    // Halves are swapped after the last round.
    assign w_pre = {w_r[16], w_l[16]};
endmodule

module des_block_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        key_load,
    input  logic [63:0] iv_in,
    input  logic        iv_load,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t      r_state;
    logic [63:0] r_key, r_blk, r_out;
    logic [1:0]  r_cnt;
    logic        r_dout_valid, r_busy;
    logic [63:0] w_des, w_blk_in;
    logic        w_idle, w_accept, w_last;

    des u_des (.i_in(r_blk), .i_key(r_key), .o_out(w_des));

    assign w_idle     = r_state == S_IDLE;
    assign w_last     = r_cnt == 2'(LATENCY - 1);
    assign w_accept   = din_valid && din_ready;
    assign dout       = r_out;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;

`ifdef DES_CBC_EN
    logic [63:0] r_chain;

    // Loads take priority over data so a block is never encrypted with a half-updated context.
    assign din_ready = w_idle && !key_load && !iv_load;
    assign w_blk_in  = din ^ r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_chain <= '0;
        else if (w_idle && iv_load)
            r_chain <= iv_in;
        else if (r_state == S_COMPUTE && w_last)
            r_chain <= w_des;
    end
`else
    logic w_unused_iv;

    assign w_unused_iv = ^{iv_in, iv_load};
    assign din_ready   = w_idle && !key_load;
    assign w_blk_in    = din;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_blk        <= '0;
            r_out        <= '0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (key_load)
                        r_key <= key_in;
                    if (w_accept) begin
                        r_blk   <= w_blk_in;
                        r_cnt   <= '0;
                        r_state <= S_COMPUTE;
                        r_busy  <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (w_last) begin
                        r_out        <= w_des;
                        r_state      <= S_DONE;
                        r_dout_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (dout_ready) begin
                        r_state      <= S_IDLE;
                        r_dout_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_block_ctrl.sv
// tb_des_block_ctrl: directed known-answer bench for des_block_ctrl (LATENCY 1 and 4 instances).
module tb_des_block_ctrl;
    localparam int LAT = 1;
    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] KA  = 64'h1111111111111111;
    localparam logic [63:0] CA1 = 64'h8A5AE1F81AB8F2DD;
    localparam logic [63:0] CA2 = 64'hF40379AB9E0EC533;
    localparam logic [63:0] KB  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CB  = 64'h17668DFC7292532D;
    localparam logic [63:0] CZ  = 64'h8CA64DE9C1B123A7;
`ifdef DES_CBC_EN
    localparam logic [63:0] B2 = 64'h9B4BF0E90BA9E3CC;
`else
    localparam logic [63:0] B2 = 64'h1111111111111111;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [63:0] key_in = '0, iv_in = '0, din = '0, dout;
    logic        key_load = 0, iv_load = 0, din_valid = 0, din_ready, dout_valid, dout_ready = 0, busy;
    logic [63:0] key_in4 = '0, iv_in4 = '0, din4 = '0, dout4;
    logic        key_load4 = 0, iv_load4 = 0, din_valid4 = 0, din_ready4, dout_valid4, dout_ready4 = 0, busy4;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    des_block_ctrl #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .iv_in(iv_in), .iv_load(iv_load),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy));

    des_block_ctrl #(.LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .key_in(key_in4), .key_load(key_load4), .iv_in(iv_in4), .iv_load(iv_load4),
        .din(din4), .din_valid(din_valid4), .din_ready(din_ready4), .dout(dout4), .dout_valid(dout_valid4),
        .dout_ready(dout_ready4), .busy(busy4));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [63:0] k, input logic [63:0] iv);
        key_in = k; iv_in = iv; key_load = 1; iv_load = 1;
        @(negedge clk);
        chk("load_rdy", 64'(din_ready), 64'd0);
        @(posedge clk); #1;
        key_load = 0; iv_load = 0;
    endtask

    task automatic send_block(input logic [63:0] d, input logic [63:0] exp, input string tag);
        int n;
        din = d; din_valid = 1; dout_ready = 1;
        #1;
        n = 0;
        while (!din_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_acc"}, 64'(din_ready), 64'd1);
        @(posedge clk); #1;
        din_valid = 0;
        n = 0;
        while (!dout_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"}, 64'(n), 64'(LAT));
        chk({tag, "_out"}, dout, exp);
        @(posedge clk); #1;
        chk({tag, "_idle"}, 64'({dout_valid, busy}), 64'd0);
    endtask

    initial begin
        int n;
        logic seen;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst_rdy", 64'(din_ready), 64'd1);
        chk("rst_val", 64'(dout_valid), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_val4", 64'(dout_valid4), 64'd0);

        // Cleared key and chain: all-zero block under the all-zero key.
        send_block(64'd0, CZ, "zero_key");

        load(K1, 64'd0);
        send_block(PT, C1, "single");

        load(KA, 64'd0);
        send_block(PT, CA1, "chain1");
        send_block(B2, CA2, "chain2");

        // Key load collides with valid data: load wins, block goes next cycle under the new key.
        key_in = KB; key_load = 1; iv_in = 64'd0; iv_load = 1; din = 64'h1111111111111111; din_valid = 1;
        @(negedge clk);
        chk("coll_rdy", 64'(din_ready), 64'd0);
        @(posedge clk); #1;
        chk("coll_noacc", 64'(busy), 64'd0);
        key_load = 0; iv_load = 0;
        send_block(64'h1111111111111111, CB, "coll");

        // Backpressure in DONE with new data waiting.
        load(K1, 64'd0);
        din = PT; din_valid = 1; dout_ready = 0;
        #1 chk("bp_acc", 64'(din_ready), 64'd1);
        @(posedge clk); #1;
        din = 64'hFFFFFFFFFFFFFFFF;
        n = 0;
        while (!dout_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_lat", 64'(n), 64'(LAT));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_dout", dout, C1);
            chk("bp_rdy", 64'(din_ready), 64'd0);
            chk("bp_val", 64'(dout_valid), 64'd1);
        end
        dout_ready = 1; din_valid = 0;
        @(posedge clk); #1;
        chk("bp_rel", 64'({dout_valid, busy}), 64'd0);
        chk("bp_hold", dout, C1);

        // Reset during COMPUTE.
        load(K1, 64'd0);
        din = PT; din_valid = 1; dout_ready = 1;
        #1 chk("rc_acc", 64'(din_ready), 64'd1);
        @(posedge clk); #1;
        chk("rc_busy1", 64'(busy), 64'd1);
        #1 rst = 1; din_valid = 0;
        #1;
        chk("rc_busy", 64'(busy), 64'd0);
        chk("rc_val", 64'(dout_valid), 64'd0);
        @(negedge clk) rst = 0;
        seen = 0;
        repeat (5) begin @(posedge clk); #1; seen |= dout_valid; end
        chk("rc_never", 64'(seen), 64'd0);
        send_block(64'd0, CZ, "rc_keyclr");
        load(K1, 64'd0);
        send_block(PT, C1, "rc_again");

        // Reset during DONE drops dout_valid without waiting for a clock edge.
        din = PT; din_valid = 1; dout_ready = 0;
        n = 0;
        while (!dout_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("rd_val1", 64'(dout_valid), 64'd1);
        din_valid = 0;
        @(negedge clk);
        #1 rst = 1;
        #1;
        chk("rd_val", 64'(dout_valid), 64'd0);
        chk("rd_dout", dout, 64'd0);
        chk("rd_busy", 64'(busy), 64'd0);
        @(negedge clk) rst = 0;

        // LATENCY = 4 instance: single block.
        @(posedge clk); #1;
        key_in4 = K1; iv_in4 = 64'd0; key_load4 = 1; iv_load4 = 1;
        @(posedge clk); #1;
        key_load4 = 0; iv_load4 = 0; din4 = PT; din_valid4 = 1; dout_ready4 = 1;
        #1 chk("l4_acc", 64'(din_ready4), 64'd1);
        @(posedge clk); #1;
        din_valid4 = 0;
        n = 0;
        while (!dout_valid4 && n < 20) begin @(posedge clk); #1; n++; end
        chk("l4_lat", 64'(n), 64'd4);
        chk("l4_out", dout4, C1);
        @(posedge clk); #1;
        chk("l4_idle", 64'({dout_valid4, busy4}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
